inst_sram_resp: RTL and testbench

- Responder end of the instruction SRAM interface driven by the fetch stage: en/wen/addr/wdata in, rdata out, fixed 1-cycle read latency.
- Word-addressed synchronous memory with byte write enables and an address window check.
- A boot-load port fills the array after reset. Until loading completes, fetches return a NOP.
- Sits between the CPU top and the memory subsystem; replaces a bare RAM macro in simulation and FPGA builds.

---
 rtl/mycpu_mem_pkg.sv | 21 ++
 rtl/inst_sram_resp_if.sv | 19 +
 rtl/sram_bytewe_1p.sv | 28 ++
 rtl/inst_sram_resp.sv | 121 ++++++++++++
 tb/tb_inst_sram_resp.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_mem_pkg.sv
// Shared definitions for the CPU-side memory responders: FSM states, default
// instruction-window constants and the address window helper.
package mycpu_mem_pkg;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } resp_state_t;

   localparam logic [31:0] INST_BASE_ADDR = 32'h1c00_0000;
   localparam logic [31:0] NOP_INST       = 32'h0340_0000;

   // True when addr falls inside the 2**aw word window that starts at byte address base.
   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned aw);
      logic [31:0] off;
      off = addr - base;
      return (off >> (aw + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// Instruction SRAM bus between the fetch stage (master) and the responder (slave).
// Contract: en qualifies wen/addr/wdata in the same cycle; rdata answers one cycle later and holds while en is low.
interface inst_sram_resp_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output inst_sram_rdata
   );
endinterface

// File: rtl/sram_bytewe_1p.sv
// Single-port synchronous RAM, 32-bit words, byte write enables, read-first.
// The read register only updates on an enabled cycle, so it holds across idle cycles.
module sram_bytewe_1p #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [0:(1<<AW)-1];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_rdata <= r_mem[i_addr];
         for (int i = 0; i < 4; i++) begin
            if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: boot-load FSM, address window decode, NOP substitution.
// Optional access counters are built when INST_SRAM_RESP_STATS_EN is defined.
module inst_sram_resp #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = mycpu_mem_pkg::INST_BASE_ADDR,
   parameter logic [31:0] NOP_INST  = mycpu_mem_pkg::NOP_INST
) (
   input  logic                       clk,
   input  logic                       reset,
   inst_sram_resp_if.slave            bus,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [ADDR_W-1:0]          load_addr,
   input  logic [31:0]                load_data,
   input  logic                       load_done,
   output logic                       running,
   output logic                       addr_err,
   output mycpu_mem_pkg::resp_state_t dbg_state
`ifdef INST_SRAM_RESP_STATS_EN
   ,
   output logic [31:0]                stat_rd,
   output logic [31:0]                stat_wr,
   output logic [15:0]                stat_err
`endif
);
   import mycpu_mem_pkg::*;

   resp_state_t       r_state, w_state_nxt;
   logic [31:0]       w_off;
   logic [ADDR_W-1:0] w_idx;
   logic              w_in_win, w_cpu_acc, w_cpu_ok, w_cpu_bad, w_load_wr;
   logic              w_ram_en;
   logic [3:0]        w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [31:0]       w_ram_wdata, w_ram_rdata;
   logic              r_src_ram, r_addr_err;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_LOAD;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      load_ready  = 1'b0;
      running     = 1'b0;
      case (r_state)
         S_LOAD: begin
            load_ready = !reset;
            if (load_done) w_state_nxt = S_RUN;
         end
         S_RUN: running = 1'b1;
         default: w_state_nxt = S_LOAD;
      endcase
   end

   assign dbg_state = r_state;

   assign w_off     = bus.inst_sram_addr - BASE_ADDR;
   assign w_idx     = ADDR_W'(w_off >> 2);
   assign w_in_win  = in_window(bus.inst_sram_addr, BASE_ADDR, ADDR_W);
   assign w_cpu_acc = (r_state == S_RUN) && bus.inst_sram_en && !reset;
   assign w_cpu_ok  = w_cpu_acc && w_in_win;
   assign w_cpu_bad = w_cpu_acc && !w_in_win;
   assign w_load_wr = (r_state == S_LOAD) && load_valid && !reset;

   // The RAM port is owned by the loader in S_LOAD and by the CPU in S_RUN.
   assign w_ram_en    = w_cpu_ok || w_load_wr;
   assign w_ram_we    = w_load_wr ? 4'hf      : (w_cpu_ok ? bus.inst_sram_wen : 4'h0);
   assign w_ram_addr  = w_load_wr ? load_addr : w_idx;
   assign w_ram_wdata = w_load_wr ? load_data : bus.inst_sram_wdata;

   sram_bytewe_1p #(.AW(ADDR_W)) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   // r_src_ram picks RAM data vs NOP; like the RAM register it only moves on en.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_ram  <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_cpu_bad;
         if (bus.inst_sram_en) r_src_ram <= w_cpu_ok;
      end
   end

   assign bus.inst_sram_rdata = r_src_ram ? w_ram_rdata : NOP_INST;
   assign addr_err            = r_addr_err;

`ifdef INST_SRAM_RESP_STATS_EN
   logic        w_rd_hit, w_wr_hit;
   logic [31:0] r_stat_rd, r_stat_wr;
   logic [15:0] r_stat_err;

   assign w_rd_hit = w_cpu_ok && (bus.inst_sram_wen == 4'h0);
   assign w_wr_hit = w_cpu_ok && (bus.inst_sram_wen != 4'h0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_rd  <= '0;
         r_stat_wr  <= '0;
         r_stat_err <= '0;
      end else begin
         if (w_rd_hit  && (r_stat_rd  != '1)) r_stat_rd  <= r_stat_rd  + 32'd1;
         if (w_wr_hit  && (r_stat_wr  != '1)) r_stat_wr  <= r_stat_wr  + 32'd1;
         if (w_cpu_bad && (r_stat_err != '1)) r_stat_err <= r_stat_err + 16'd1;
      end
   end

   assign stat_rd  = r_stat_rd;
   assign stat_wr  = r_stat_wr;
   assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: directed table, corner sequences, random traffic vs a word-level model.
module tb_inst_sram_resp;
   import mycpu_mem_pkg::*;

   localparam int          AW   = 12;
   localparam logic [31:0] BASE = 32'h1c00_0000;
   localparam logic [31:0] NOP  = 32'h0340_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              load_valid, load_ready, load_done, running, addr_err;
   logic [AW-1:0]     load_addr;
   logic [31:0]       load_data;
   resp_state_t       dbg_state;
`ifdef INST_SRAM_RESP_STATS_EN
   logic [31:0]       stat_rd, stat_wr;
   logic [15:0]       stat_err;
`endif

   always #5 clk = ~clk;

   inst_sram_resp_if bus ();

   inst_sram_resp #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_done  (load_done),
      .running    (running),
      .addr_err   (addr_err),
      .dbg_state  (dbg_state)
`ifdef INST_SRAM_RESP_STATS_EN
      ,
      .stat_rd    (stat_rd),
      .stat_wr    (stat_wr),
      .stat_err   (stat_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard and reference model: word-indexed memory image plus access counts.
   logic [31:0] exp_q[$];
   logic [31:0] mem_m [int unsigned];
   logic [31:0] exp_hold;
   int          n_rd, n_wr, n_err;

   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_access(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] er, output logic ee);
      logic [31:0] off;
      logic [31:0] w;
      int unsigned idx;
      ee = 1'b0;
      if (!en) begin
         er = exp_hold;
      end else begin
         off = addr - BASE;
         if (off < 32'(4 * (1 << AW))) begin
            idx = off / 4;
            w   = mem_m[idx];
            er  = w;
            if (wen == 4'h0) n_rd++;
            else begin
               n_wr++;
               for (int b = 0; b < 4; b++) if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
               mem_m[idx] = w;
            end
         end else begin
            er = NOP;
            ee = 1'b1;
            n_err++;
         end
         exp_hold = er;
      end
   endtask

   // One CPU cycle in S_RUN; use_fixed selects hand-derived expectations over the model's.
   task automatic access(input string name, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic use_fixed, input logic [31:0] fx_r, input logic fx_e);
      logic [31:0] mr, er;
      logic        me;
      model_access(en, wen, addr, wdata, mr, me);
      exp_q.push_back(use_fixed ? fx_r : mr);
      bus.inst_sram_en    = en;
      bus.inst_sram_wen   = wen;
      bus.inst_sram_addr  = addr;
      bus.inst_sram_wdata = wdata;
      step();
      er = exp_q.pop_front();
      chk({name, " rdata"}, bus.inst_sram_rdata, er);
      chk({name, " addr_err"}, 32'(addr_err), 32'(use_fixed ? fx_e : me));
      bus.inst_sram_en = 1'b0;
   endtask

   task automatic load_word(input int unsigned idx, input logic [31:0] data, input logic done);
      chk("load_ready while loading", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_addr  = AW'(idx);
      load_data  = data;
      load_done  = done;
      step();
      load_valid = 1'b0;
      load_done  = 1'b0;
      mem_m[idx] = data;
   endtask

   task automatic random_access(input string name);
      logic [31:0] addr;
      int unsigned r, idx;
      r = $urandom_range(0, 9);
      if (r < 7) begin
         idx  = (r == 6) ? 4095 : $urandom_range(0, 63);
         addr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      end else if (r == 7) begin
         addr = BASE - 32'($urandom_range(1, 1000));
      end else begin
         addr = BASE + 32'h4000 + 32'($urandom_range(0, 32'h7fff_ffff));
      end
      access(name, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
             addr, $urandom, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 32'h1c00_0000, 32'h0,         32'h0280_0421, 1'b0};
      tbl[1]  = '{1'b1, 4'h0, 32'h1c00_0004, 32'h0,         32'h0280_0842, 1'b0};
      tbl[2]  = '{1'b1, 4'h5, 32'h1c00_0008, 32'haabb_ccdd, 32'h1122_3344, 1'b0};
      tbl[3]  = '{1'b1, 4'h0, 32'h1c00_0008, 32'h0,         32'h11bb_33dd, 1'b0};
      tbl[4]  = '{1'b1, 4'h0, 32'h1c00_4000, 32'h0,         NOP,           1'b1};
      tbl[5]  = '{1'b0, 4'h0, 32'h1c00_0000, 32'h0,         NOP,           1'b0};
      tbl[6]  = '{1'b1, 4'h0, 32'h1c00_0006, 32'h0,         32'h0280_0842, 1'b0};
      tbl[7]  = '{1'b1, 4'h0, 32'h1bff_fffc, 32'h0,         NOP,           1'b1};
      tbl[8]  = '{1'b1, 4'hf, 32'h1c00_0008, 32'h1234_5678, 32'h11bb_33dd, 1'b0};
      tbl[9]  = '{1'b1, 4'hf, 32'h1c00_4008, 32'h9999_9999, NOP,           1'b1};
      tbl[10] = '{1'b1, 4'h0, 32'h1c00_0008, 32'h0,         32'h1234_5678, 1'b0};
      tbl[11] = '{1'b1, 4'h0, 32'h1c00_3ffc, 32'h0,         32'hdead_beef, 1'b0};
      tbl[12] = '{1'b1, 4'h0, 32'hffff_ffff, 32'h0,         NOP,           1'b1};
      tbl[13] = '{1'b1, 4'h8, 32'h1c00_3ffd, 32'h1100_0000, 32'hdead_beef, 1'b0};
      tbl[14] = '{1'b1, 4'h0, 32'h1c00_3ffc, 32'h0,         32'h11ad_beef, 1'b0};

      reset               = 1'b1;
      bus.inst_sram_en    = 1'b0;
      bus.inst_sram_wen   = 4'h0;
      bus.inst_sram_addr  = 32'h0;
      bus.inst_sram_wdata = 32'h0;
      load_valid          = 1'b0;
      load_addr           = '0;
      load_data           = 32'h0;
      load_done           = 1'b0;
      exp_hold = NOP; n_rd = 0; n_wr = 0; n_err = 0;

      step();
      step();
      chk("reset rdata", bus.inst_sram_rdata, NOP);
      chk("reset running", 32'(running), 32'd0);
      chk("reset load_ready", 32'(load_ready), 32'd0);
      chk("reset addr_err", 32'(addr_err), 32'd0);
      reset = 1'b0;
      #1;
      chk("load state", 32'(dbg_state), 32'(S_LOAD));
      chk("load_ready after reset", 32'(load_ready), 32'd1);

      // CPU read while still loading returns NOP.
      bus.inst_sram_en   = 1'b1;
      bus.inst_sram_addr = BASE;
      step();
      bus.inst_sram_en   = 1'b0;
      chk("load-phase rdata", bus.inst_sram_rdata, NOP);
      chk("load-phase running", 32'(running), 32'd0);
      chk("load-phase load_ready", 32'(load_ready), 32'd1);

      load_word(0, 32'h0280_0421, 1'b0);
      load_word(1, 32'h0280_0842, 1'b0);
      load_word(2, 32'h1122_3344, 1'b0);
      for (int i = 3; i < 64; i++) load_word(i, $urandom, 1'b0);
      load_word(4095, 32'hdead_beef, 1'b1);
      chk("run running", 32'(running), 32'd1);
      chk("run load_ready", 32'(load_ready), 32'd0);
      chk("run state", 32'(dbg_state), 32'(S_RUN));

      for (int i = 0; i < 15; i++)
         access($sformatf("tbl%0d", i), tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata,
                1'b1, tbl[i].exp_rdata, tbl[i].exp_err);

      // Read then a stall: rdata must hold while en is low, whatever the other inputs do.
      access("hold read", 1'b1, 4'h0, BASE, 32'h0, 1'b1, 32'h0280_0421, 1'b0);
      for (int i = 0; i < 5; i++)
         access($sformatf("hold%0d", i), 1'b0, 4'($urandom), $urandom, $urandom, 1'b1, 32'h0280_0421, 1'b0);

      // Loader is ignored once running.
      load_valid = 1'b1; load_addr = '0; load_data = 32'hffff_ffff;
      step();
      load_valid = 1'b0;
      chk("run ignores load running", 32'(running), 32'd1);
      access("run ignores load", 1'b1, 4'h0, BASE, 32'h0, 1'b1, 32'h0280_0421, 1'b0);

      for (int i = 0; i < 400; i++) random_access($sformatf("rand%0d", i));

`ifdef INST_SRAM_RESP_STATS_EN
      chk("stat_rd", stat_rd, 32'(n_rd));
      chk("stat_wr", stat_wr, 32'(n_wr));
      chk("stat_err", 32'(stat_err), 32'(n_err));
`endif

      // Reset in the middle of a stream restarts loading.
      reset = 1'b1;
      bus.inst_sram_en = 1'b1; bus.inst_sram_wen = 4'h0; bus.inst_sram_addr = BASE;
      step();
      reset = 1'b0;
      bus.inst_sram_en = 1'b0;
      #1;
      chk("mid reset running", 32'(running), 32'd0);
      chk("mid reset load_ready", 32'(load_ready), 32'd1);
      chk("mid reset rdata", bus.inst_sram_rdata, NOP);
      chk("mid reset addr_err", 32'(addr_err), 32'd0);
      exp_hold = NOP; n_rd = 0; n_wr = 0; n_err = 0;
`ifdef INST_SRAM_RESP_STATS_EN
      chk("stat_rd cleared", stat_rd, 32'd0);
      chk("stat_err cleared", 32'(stat_err), 32'd0);
`endif
      load_word(0, 32'h0bad_f00d, 1'b1);
      chk("reload running", 32'(running), 32'd1);
      access("reload read0", 1'b1, 4'h0, BASE, 32'h0, 1'b1, 32'h0bad_f00d, 1'b0);
      for (int i = 0; i < 40; i++) random_access($sformatf("post%0d", i));
`ifdef INST_SRAM_RESP_STATS_EN
      chk("stat_rd post", stat_rd, 32'(n_rd));
      chk("stat_wr post", stat_wr, 32'(n_wr));
      chk("stat_err post", 32'(stat_err), 32'(n_err));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
